ysyx_23060203_mem_arbiter: RTL
==============================

// Module: ysyx_23060203_mem_arbiter
// PURPOSE
//  Shares the single downstream AXI memory port between IFU (read only) and the EXU's LSU (read+write).
//  Read channel: one outstanding burst, fixed LSU priority with IFU anti-starvation aging.
//  Write channel: LSU-only pass-through with in-flight tracking; optional read-after-write ordering.
//  Sits between IFU/EXU and the crossbar/SoC master port.
// PARAMETERS
//  MAX_WAIT   4   consecutive LSU read grants while IFU waits before IFU is forced to win (1..15)
//  RAW_ORDER  1   1: an LSU read is not granted while an LSU write is in flight (AW issued, B not yet taken)
// PORTS
//  clock   input   1        single clock, all state on posedge
//  reset   input   1        asynchronous, active-low (0 = reset)
//  ifu_r   axi_if.in  -     IFU read requester (AR/R channels)
//  lsu_r   axi_if.in  -     LSU read requester (AR/R channels)
//  lsu_w   axi_if.in  -     LSU write requester (AW/W/B channels)
//  out_r   axi_if.out -     downstream read port
//  out_w   axi_if.out -     downstream write port
//  busy    output  1        read FSM != R_IDLE or write FSM != W_IDLE (perf/debug)
// BEHAVIOUR
//  Reset: r_state=R_IDLE, w_state=W_IDLE, grant=NONE, age_cnt=0. All valid/ready outputs 0 during reset
//   and in the first cycle after release. Reset mid-burst abandons the transaction; no replay.
//  Read FSM R_IDLE -> R_ADDR -> R_DATA -> R_IDLE:
//   R_IDLE: sample ifu_r.arvalid/lsu_r.arvalid, register grant, go R_ADDR. No AR is forwarded in R_IDLE,
//    so the grant takes effect 1 cycle after the request (arbitration latency 1).
//   Pick: LSU wins unless (age_cnt==MAX_WAIT && ifu arvalid) or (RAW_ORDER && w_state!=W_IDLE).
//    If LSU is blocked by RAW and IFU is not requesting, stay in R_IDLE.
//   R_ADDR: out_r.ar* = granted master's ar*; granted arready = out_r.arready; other master arready=0.
//    On out_r AR handshake -> R_DATA.
//   R_DATA: out_r.r* steered to granted master; out_r.rready = granted rready; other rvalid=0.
//    On R handshake with rlast=1 -> R_IDLE (grant released same edge; next grant earliest +1 cycle).
//   rresp passed through unmodified; an error response still ends the burst.
//  Aging: age_cnt increments (saturating at MAX_WAIT) on each LSU grant made while ifu arvalid=1;
//   clears to 0 on any IFU grant. A requester must keep arvalid and ar* stable until arready (AXI rule).
//  Write FSM W_IDLE -> W_SEND -> W_RESP -> W_IDLE:
//   W_IDLE: on lsu_w.awvalid go W_SEND (no forwarding in W_IDLE, latency 1).
//   W_SEND: AW and W forwarded independently; aw_done/w_done flags record each handshake;
//    after a channel's handshake its forwarded valid is forced 0. When both are done -> W_RESP.
//    AW and W completing in the same cycle is legal. Single-beat writes only (wlast must be 1).
//   W_RESP: out_w.b* forwarded to LSU; on B handshake -> W_IDLE, flags clear.
//  Simultaneous: LSU read and write requests in the same R_IDLE/W_IDLE cycle with RAW_ORDER=1: the write
//   starts and the read waits until W_RESP completes. With RAW_ORDER=0 both proceed concurrently.
//  No combinational path from any downstream ready to any downstream valid.
// STRUCTURE
//  Package ysyx_23060203_arb_pkg: typedef enum r_state_t {R_IDLE,R_ADDR,R_DATA};
//   typedef enum w_state_t {W_IDLE,W_SEND,W_RESP}; typedef enum grant_t {GNT_NONE,GNT_IFU,GNT_LSU}.
//  Sub-module ysyx_23060203_arb_pick: grant selection + age_cnt register (params MAX_WAIT, RAW_ORDER).
//  Top: the two FSMs plus channel steering muxes.
// TESTING
//  IFU-only AR addr=0x3000_0000, 4-beat burst, rlast on beat 4 -> IFU arready 1 cycle after arvalid,
//   4 beats delivered, busy falls the cycle after the last beat.
//  IFU and LSU arvalid in the same cycle, MAX_WAIT=4 -> LSU granted; IFU rvalid and arready stay 0 throughout.
//  Aging: LSU issues back-to-back reads while IFU arvalid is held -> after 4 LSU grants the 5th grant goes
//   to IFU; age_cnt reads 0 afterwards.
//  RAW: LSU AW 0x8000_0010 and AR 0x8000_0010 in the same cycle, B delayed 5 cycles -> out_r.arvalid stays 0
//   until the cycle after the B handshake; RAW_ORDER=0 -> AR issues in parallel.
//  Write with W accepted 3 cycles before AW -> out_w.wvalid drops after its handshake, one B to LSU,
//   bresp=2'b10 is passed through.
//  Async reset asserted mid-R_DATA beat 2 -> all valids 0 immediately; after release IFU arvalid is granted
//   normally starting from R_IDLE.

Source files
------------

// File: rtl/ysyx_23060203_arb_pkg.sv
// Shared types and widths for the IFU/LSU memory arbiter.
package ysyx_23060203_arb_pkg;

    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_SEND, W_RESP} w_state_t;
    typedef enum logic [1:0] {GNT_NONE, GNT_IFU, GNT_LSU} grant_t;

    localparam int unsigned AgeW = 4;

endpackage

// File: rtl/ysyx_23060203_arb_pick.sv
// Read grant selection: fixed LSU priority, IFU aging, optional read-after-write hold-off.
module ysyx_23060203_arb_pick
    import ysyx_23060203_arb_pkg::*;
#(
    parameter int unsigned MAX_WAIT  = 4,
    parameter bit          RAW_ORDER = 1'b1
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       pick_en_i,
    input  logic       ifu_req_i,
    input  logic       lsu_req_i,
    input  logic       wr_busy_i,
    output logic [1:0] grant_o
);

    logic [AgeW-1:0] age_q, age_d;
    grant_t          grant;
    logic            lsu_blocked;
    logic            ifu_aged;

    assign lsu_blocked = RAW_ORDER && wr_busy_i;
    assign ifu_aged    = (age_q == AgeW'(MAX_WAIT)) && ifu_req_i;

    always_comb begin
        grant = GNT_NONE;
        if (lsu_req_i && !lsu_blocked && !ifu_aged) begin
            grant = GNT_LSU;
        end else if (ifu_req_i) begin
            grant = GNT_IFU;
        end
    end

    // Age only moves when a grant is actually registered (read FSM idle).
    always_comb begin
        age_d = age_q;
        if (pick_en_i) begin
            if (grant == GNT_LSU && ifu_req_i && age_q < AgeW'(MAX_WAIT)) begin
                age_d = age_q + 1'b1;
            end else if (grant == GNT_IFU) begin
                age_d = '0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            age_q <= '0;
        end else begin
            age_q <= age_d;
        end
    end

    assign grant_o = grant;

endmodule

// File: rtl/ysyx_23060203_mem_arbiter.sv
// Shares one downstream AXI port between IFU reads and LSU reads/writes.
module ysyx_23060203_mem_arbiter
    import ysyx_23060203_arb_pkg::*;
#(
    parameter int unsigned MAX_WAIT  = 4,
    parameter bit          RAW_ORDER = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    // IFU read requester
    input  logic        ifu_r_arvalid,
    output logic        ifu_r_arready,
    input  logic [31:0] ifu_r_araddr,
    input  logic [3:0]  ifu_r_arid,
    input  logic [7:0]  ifu_r_arlen,
    input  logic [2:0]  ifu_r_arsize,
    input  logic [1:0]  ifu_r_arburst,
    output logic        ifu_r_rvalid,
    input  logic        ifu_r_rready,
    output logic [31:0] ifu_r_rdata,
    output logic [1:0]  ifu_r_rresp,
    output logic        ifu_r_rlast,
    output logic [3:0]  ifu_r_rid,
    // LSU read requester
    input  logic        lsu_r_arvalid,
    output logic        lsu_r_arready,
    input  logic [31:0] lsu_r_araddr,
    input  logic [3:0]  lsu_r_arid,
    input  logic [7:0]  lsu_r_arlen,
    input  logic [2:0]  lsu_r_arsize,
    input  logic [1:0]  lsu_r_arburst,
    output logic        lsu_r_rvalid,
    input  logic        lsu_r_rready,
    output logic [31:0] lsu_r_rdata,
    output logic [1:0]  lsu_r_rresp,
    output logic        lsu_r_rlast,
    output logic [3:0]  lsu_r_rid,
    // LSU write requester
    input  logic        lsu_w_awvalid,
    output logic        lsu_w_awready,
    input  logic [31:0] lsu_w_awaddr,
    input  logic [3:0]  lsu_w_awid,
    input  logic [7:0]  lsu_w_awlen,
    input  logic [2:0]  lsu_w_awsize,
    input  logic [1:0]  lsu_w_awburst,
    input  logic        lsu_w_wvalid,
    output logic        lsu_w_wready,
    input  logic [31:0] lsu_w_wdata,
    input  logic [3:0]  lsu_w_wstrb,
    input  logic        lsu_w_wlast,
    output logic        lsu_w_bvalid,
    input  logic        lsu_w_bready,
    output logic [1:0]  lsu_w_bresp,
    output logic [3:0]  lsu_w_bid,
    // Downstream read port
    output logic        out_r_arvalid,
    input  logic        out_r_arready,
    output logic [31:0] out_r_araddr,
    output logic [3:0]  out_r_arid,
    output logic [7:0]  out_r_arlen,
    output logic [2:0]  out_r_arsize,
    output logic [1:0]  out_r_arburst,
    input  logic        out_r_rvalid,
    output logic        out_r_rready,
    input  logic [31:0] out_r_rdata,
    input  logic [1:0]  out_r_rresp,
    input  logic        out_r_rlast,
    input  logic [3:0]  out_r_rid,
    // Downstream write port
    output logic        out_w_awvalid,
    input  logic        out_w_awready,
    output logic [31:0] out_w_awaddr,
    output logic [3:0]  out_w_awid,
    output logic [7:0]  out_w_awlen,
    output logic [2:0]  out_w_awsize,
    output logic [1:0]  out_w_awburst,
    output logic        out_w_wvalid,
    input  logic        out_w_wready,
    output logic [31:0] out_w_wdata,
    output logic [3:0]  out_w_wstrb,
    output logic        out_w_wlast,
    input  logic        out_w_bvalid,
    output logic        out_w_bready,
    input  logic [1:0]  out_w_bresp,
    input  logic [3:0]  out_w_bid,
    output logic        busy
);

    r_state_t   r_state_q, r_state_d;
    w_state_t   w_state_q, w_state_d;
    grant_t     grant_q, grant_d;
    logic       aw_done_q, aw_done_d;
    logic       w_done_q, w_done_d;
    logic [1:0] pick_grant;
    logic       wr_busy;
    logic       sel_lsu;

    // A write about to start also holds off LSU reads so it is ordered first.
    assign wr_busy = (w_state_q != W_IDLE) || lsu_w_awvalid;
    assign sel_lsu = (grant_q == GNT_LSU);

    ysyx_23060203_arb_pick #(
        .MAX_WAIT  (MAX_WAIT),
        .RAW_ORDER (RAW_ORDER)
    ) u_pick (
        .clk_i     (clock),
        .rst_ni    (reset),
        .pick_en_i (r_state_q == R_IDLE),
        .ifu_req_i (ifu_r_arvalid),
        .lsu_req_i (lsu_r_arvalid),
        .wr_busy_i (wr_busy),
        .grant_o   (pick_grant)
    );

    // Read channel steering
    always_comb begin
        out_r_araddr  = sel_lsu ? lsu_r_araddr  : ifu_r_araddr;
        out_r_arid    = sel_lsu ? lsu_r_arid    : ifu_r_arid;
        out_r_arlen   = sel_lsu ? lsu_r_arlen   : ifu_r_arlen;
        out_r_arsize  = sel_lsu ? lsu_r_arsize  : ifu_r_arsize;
        out_r_arburst = sel_lsu ? lsu_r_arburst : ifu_r_arburst;
        out_r_arvalid = 1'b0;
        ifu_r_arready = 1'b0;
        lsu_r_arready = 1'b0;
        out_r_rready  = 1'b0;
        ifu_r_rvalid  = 1'b0;
        lsu_r_rvalid  = 1'b0;
        if (r_state_q == R_ADDR) begin
            out_r_arvalid = (grant_q == GNT_IFU) ? ifu_r_arvalid : (sel_lsu && lsu_r_arvalid);
            ifu_r_arready = (grant_q == GNT_IFU) && out_r_arready;
            lsu_r_arready = sel_lsu && out_r_arready;
        end
        if (r_state_q == R_DATA) begin
            out_r_rready = (grant_q == GNT_IFU) ? ifu_r_rready : (sel_lsu && lsu_r_rready);
            ifu_r_rvalid = (grant_q == GNT_IFU) && out_r_rvalid;
            lsu_r_rvalid = sel_lsu && out_r_rvalid;
        end
    end

    assign ifu_r_rdata = out_r_rdata;
    assign ifu_r_rresp = out_r_rresp;
    assign ifu_r_rlast = out_r_rlast;
    assign ifu_r_rid   = out_r_rid;
    assign lsu_r_rdata = out_r_rdata;
    assign lsu_r_rresp = out_r_rresp;
    assign lsu_r_rlast = out_r_rlast;
    assign lsu_r_rid   = out_r_rid;

    always_comb begin
        r_state_d = r_state_q;
        grant_d   = grant_q;
        unique case (r_state_q)
            R_IDLE: begin
                if (grant_t'(pick_grant) != GNT_NONE) begin
                    grant_d   = grant_t'(pick_grant);
                    r_state_d = R_ADDR;
                end
            end
            R_ADDR: begin
                if (out_r_arvalid && out_r_arready) r_state_d = R_DATA;
            end
            R_DATA: begin
                if (out_r_rvalid && out_r_rready && out_r_rlast) begin
                    r_state_d = R_IDLE;
                    grant_d   = GNT_NONE;
                end
            end
            default: begin
                r_state_d = R_IDLE;
                grant_d   = GNT_NONE;
            end
        endcase
    end

    // Write channel steering: AW and W complete independently, then B.
    always_comb begin
        out_w_awaddr  = lsu_w_awaddr;
        out_w_awid    = lsu_w_awid;
        out_w_awlen   = lsu_w_awlen;
        out_w_awsize  = lsu_w_awsize;
        out_w_awburst = lsu_w_awburst;
        out_w_wdata   = lsu_w_wdata;
        out_w_wstrb   = lsu_w_wstrb;
        out_w_wlast   = lsu_w_wlast;
        out_w_awvalid = (w_state_q == W_SEND) && !aw_done_q && lsu_w_awvalid;
        lsu_w_awready = (w_state_q == W_SEND) && !aw_done_q && out_w_awready;
        out_w_wvalid  = (w_state_q == W_SEND) && !w_done_q && lsu_w_wvalid;
        lsu_w_wready  = (w_state_q == W_SEND) && !w_done_q && out_w_wready;
        out_w_bready  = (w_state_q == W_RESP) && lsu_w_bready;
        lsu_w_bvalid  = (w_state_q == W_RESP) && out_w_bvalid;
    end

    assign lsu_w_bresp = out_w_bresp;
    assign lsu_w_bid   = out_w_bid;

    always_comb begin
        w_state_d = w_state_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        unique case (w_state_q)
            W_IDLE: begin
                if (lsu_w_awvalid) w_state_d = W_SEND;
            end
            W_SEND: begin
                aw_done_d = aw_done_q || (out_w_awvalid && out_w_awready);
                w_done_d  = w_done_q || (out_w_wvalid && out_w_wready);
                if (aw_done_d && w_done_d) w_state_d = W_RESP;
            end
            W_RESP: begin
                if (out_w_bvalid && out_w_bready) begin
                    w_state_d = W_IDLE;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end
            end
            default: begin
                w_state_d = W_IDLE;
                aw_done_d = 1'b0;
                w_done_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state_q <= R_IDLE;
            grant_q   <= GNT_NONE;
            w_state_q <= W_IDLE;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            r_state_q <= r_state_d;
            grant_q   <= grant_d;
            w_state_q <= w_state_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

    assign busy = (r_state_q != R_IDLE) || (w_state_q != W_IDLE);

endmodule
